// File: rtl/mdio_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mdio_pkg
// Brief    : Shared constants for the Clause 22 MDIO responder: frame field
//            widths, start/opcode codes, FSM state encodings and a helper.
// Revision : 1.0 - initial release
// ============================================================================
package mdio_pkg;

  // Frame field widths
  localparam int PHYAD_W = 5;
  localparam int REGAD_W = 5;
  localparam int DATA_W  = 16;

  // Start-of-frame and opcode codes, transmitted MSB first
  localparam logic [1:0] ST       = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;
  localparam logic [1:0] OP_WRITE = 2'b01;

  // Frame decoder states
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ST2   = 3'd1;
  localparam logic [2:0] S_OP    = 3'd2;
  localparam logic [2:0] S_PHYAD = 3'd3;
  localparam logic [2:0] S_REGAD = 3'd4;
  localparam logic [2:0] S_TA    = 3'd5;
  localparam logic [2:0] S_DATA  = 3'd6;

  // Increment that sticks at lim once reached
  function automatic logic [5:0] sat_inc(input logic [5:0] v, input logic [5:0] lim);
    return (v >= lim) ? lim : v + 6'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mdio_sync_edge.sv
`default_nettype none
// ============================================================================
// Module   : mdio_sync_edge
// Brief    : Two-flop synchronizer with optional rising-edge detect. Every
//            instance has the same latency so synchronized signals stay
//            aligned with each other.
// Revision : 1.0 - initial release
// ============================================================================
module mdio_sync_edge #(
  parameter bit EDGE_EN = 1'b1
) (
  input  logic clock,
  input  logic reset,
  input  logic d_i,
  output logic q_o,
  output logic rise_o
);

  logic [1:0] sync_q;

  // Two-stage metastability filter
  always_ff @(posedge clock or posedge reset) begin
    if (reset) sync_q <= 2'b00;
    else       sync_q <= {sync_q[0], d_i};
  end

  assign q_o = sync_q[1];

  generate
    if (EDGE_EN) begin : g_edge
      logic prev_q;

      // Remember last synchronized level to spot 0->1 transitions
      always_ff @(posedge clock or posedge reset) begin
        if (reset) prev_q <= 1'b0;
        else       prev_q <= sync_q[1];
      end

      assign rise_o = sync_q[1] & ~prev_q;
    end else begin : g_no_edge
      assign rise_o = 1'b0;
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/mdio_slave.sv
`default_nettype none
// ============================================================================
// Module   : mdio_slave
// Brief    : IEEE 802.3 Clause 22 MDIO responder. Oversamples MDC/MDIO in the
//            system clock domain, decodes frames for PHY_ADDR and presents
//            them as a simple register read/write strobe interface.
// Revision : 1.0 - initial release
// ============================================================================
module mdio_slave
  import mdio_pkg::*;
#(
  parameter logic [PHYAD_W-1:0] PHY_ADDR     = 5'd1,
  parameter int                 PREAMBLE_LEN = 32
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                mdc,
  input  logic                mdio_i,
  output logic                mdio_o,
  output logic                mdio_oe,
  output logic                wr_strobe,
  output logic [REGAD_W-1:0]  wr_addr,
  output logic [DATA_W-1:0]   wr_data,
  output logic                rd_strobe,
  output logic [REGAD_W-1:0]  rd_addr,
  input  logic [DATA_W-1:0]   rd_data,
  output logic                frame_abort
);

  localparam logic [5:0] PRE_MAX = 6'(PREAMBLE_LEN);

  // --------------------------------------------------------------------------
  // Input capture: identical synchronizers keep MDC and MDIO aligned
  // --------------------------------------------------------------------------
  logic w_rise;
  logic w_bit;
  logic w_mdc_level_unused;
  logic w_mdio_rise_unused;

  mdio_sync_edge #(.EDGE_EN(1'b1)) u_sync_mdc (
    .clock  (clock),
    .reset  (reset),
    .d_i    (mdc),
    .q_o    (w_mdc_level_unused),
    .rise_o (w_rise)
  );

  mdio_sync_edge #(.EDGE_EN(1'b0)) u_sync_mdio (
    .clock  (clock),
    .reset  (reset),
    .d_i    (mdio_i),
    .q_o    (w_bit),
    .rise_o (w_mdio_rise_unused)
  );

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [2:0]          state_q,   state_d;
  logic [5:0]          pre_cnt_q, pre_cnt_d;
  logic [3:0]          bit_cnt_q, bit_cnt_d;
  logic                is_read_q, is_read_d;
  logic                op_hi_q,   op_hi_d;
  logic [PHYAD_W-1:0]  phy_sh_q,  phy_sh_d;
  logic [REGAD_W-1:0]  reg_sh_q,  reg_sh_d;
  logic [DATA_W-1:0]   rx_sh_q,   rx_sh_d;
  logic [DATA_W-1:0]   tx_sh_q,   tx_sh_d;
  logic                mdio_o_q,  mdio_o_d;
  logic                mdio_oe_q, mdio_oe_d;
  logic                wr_stb_q,  wr_stb_d;
  logic [REGAD_W-1:0]  wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]   wr_data_q, wr_data_d;
  logic                rd_stb_q,  rd_stb_d;
  logic [REGAD_W-1:0]  rd_addr_q, rd_addr_d;
  logic                abort_q,   abort_d;

  // Shifted views including the bit arriving on this rise
  logic [PHYAD_W-1:0] w_phy_next;
  logic [REGAD_W-1:0] w_reg_next;
  logic [DATA_W-1:0]  w_rx_next;

  assign w_phy_next = {phy_sh_q[PHYAD_W-2:0], w_bit};
  assign w_reg_next = {reg_sh_q[REGAD_W-2:0], w_bit};
  assign w_rx_next  = {rx_sh_q[DATA_W-2:0], w_bit};

  // Frame decoder: advances only on synchronized MDC rising edges
  always_comb begin
    state_d   = state_q;
    pre_cnt_d = pre_cnt_q;
    bit_cnt_d = bit_cnt_q;
    is_read_d = is_read_q;
    op_hi_d   = op_hi_q;
    phy_sh_d  = phy_sh_q;
    reg_sh_d  = reg_sh_q;
    rx_sh_d   = rx_sh_q;
    tx_sh_d   = tx_sh_q;
    mdio_o_d  = mdio_o_q;
    mdio_oe_d = mdio_oe_q;
    wr_stb_d  = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    rd_stb_d  = 1'b0;
    rd_addr_d = rd_addr_q;
    abort_d   = 1'b0;

    if (w_rise) begin
      case (state_q)
        S_IDLE: begin
          if (w_bit == ST[1]) begin
            // A zero either starts a frame or breaks the preamble run;
            // the count is consumed either way so each frame needs a fresh one
            if (pre_cnt_q == PRE_MAX) state_d = S_ST2;
            pre_cnt_d = 6'd0;
          end else begin
            pre_cnt_d = sat_inc(pre_cnt_q, PRE_MAX);
          end
        end

        S_ST2: begin
          if (w_bit == ST[0]) begin
            state_d   = S_OP;
            bit_cnt_d = 4'd0;
          end else begin
            abort_d   = 1'b1;
            pre_cnt_d = 6'd0;
            state_d   = S_IDLE;
          end
        end

        S_OP: begin
          if (bit_cnt_q == 4'd0) begin
            op_hi_d   = w_bit;
            bit_cnt_d = 4'd1;
          end else begin
            bit_cnt_d = 4'd0;
            if ({op_hi_q, w_bit} == OP_READ) begin
              is_read_d = 1'b1;
              state_d   = S_PHYAD;
            end else if ({op_hi_q, w_bit} == OP_WRITE) begin
              is_read_d = 1'b0;
              state_d   = S_PHYAD;
            end else begin
              abort_d   = 1'b1;
              pre_cnt_d = 6'd0;
              state_d   = S_IDLE;
            end
          end
        end

        S_PHYAD: begin
          phy_sh_d = w_phy_next;
          if (bit_cnt_q == 4'(PHYAD_W - 1)) begin
            bit_cnt_d = 4'd0;
            // Frames for another PHY are ignored without any indication
            state_d   = (w_phy_next == PHY_ADDR) ? S_REGAD : S_IDLE;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end

        S_REGAD: begin
          reg_sh_d = w_reg_next;
          if (bit_cnt_q == 4'(REGAD_W - 1)) begin
            bit_cnt_d = 4'd0;
            state_d   = S_TA;
            if (is_read_q) begin
              rd_stb_d  = 1'b1;
              rd_addr_d = w_reg_next;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end

        S_TA: begin
          if (bit_cnt_q == 4'd0) begin
            bit_cnt_d = 4'd1;
            if (is_read_q) begin
              // Local logic has had the whole TA1 bit time to present data
              tx_sh_d   = rd_data;
              mdio_oe_d = 1'b1;
              mdio_o_d  = 1'b0;
            end else if (w_bit != 1'b1) begin
              abort_d   = 1'b1;
              pre_cnt_d = 6'd0;
              state_d   = S_IDLE;
            end
          end else begin
            bit_cnt_d = 4'd0;
            if (is_read_q) begin
              mdio_o_d = tx_sh_q[DATA_W-1];
              tx_sh_d  = {tx_sh_q[DATA_W-2:0], 1'b0};
              state_d  = S_DATA;
            end else if (w_bit != 1'b0) begin
              abort_d   = 1'b1;
              pre_cnt_d = 6'd0;
              state_d   = S_IDLE;
            end else begin
              state_d = S_DATA;
            end
          end
        end

        S_DATA: begin
          if (is_read_q) begin
            if (bit_cnt_q == 4'(DATA_W - 1)) begin
              mdio_oe_d = 1'b0;
              mdio_o_d  = 1'b0;
              state_d   = S_IDLE;
            end else begin
              // Present the next bit well ahead of the master's sample edge
              mdio_o_d  = tx_sh_q[DATA_W-1];
              tx_sh_d   = {tx_sh_q[DATA_W-2:0], 1'b0};
              bit_cnt_d = bit_cnt_q + 4'd1;
            end
          end else begin
            rx_sh_d = w_rx_next;
            if (bit_cnt_q == 4'(DATA_W - 1)) begin
              wr_stb_d  = 1'b1;
              wr_addr_d = reg_sh_q;
              wr_data_d = w_rx_next;
              state_d   = S_IDLE;
            end else begin
              bit_cnt_d = bit_cnt_q + 4'd1;
            end
          end
        end

        default: begin
          state_d   = S_IDLE;
          pre_cnt_d = 6'd0;
        end
      endcase
    end

    // The pad may only be driven during the turnaround/data part of a read
    if (!(is_read_d && (state_d == S_TA || state_d == S_DATA))) begin
      mdio_oe_d = 1'b0;
      mdio_o_d  = 1'b0;
    end
  end

  // State and output registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      pre_cnt_q <= 6'd0;
      bit_cnt_q <= 4'd0;
      is_read_q <= 1'b0;
      op_hi_q   <= 1'b0;
      phy_sh_q  <= '0;
      reg_sh_q  <= '0;
      rx_sh_q   <= '0;
      tx_sh_q   <= '0;
      mdio_o_q  <= 1'b0;
      mdio_oe_q <= 1'b0;
      wr_stb_q  <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      rd_stb_q  <= 1'b0;
      rd_addr_q <= '0;
      abort_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pre_cnt_q <= pre_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      is_read_q <= is_read_d;
      op_hi_q   <= op_hi_d;
      phy_sh_q  <= phy_sh_d;
      reg_sh_q  <= reg_sh_d;
      rx_sh_q   <= rx_sh_d;
      tx_sh_q   <= tx_sh_d;
      mdio_o_q  <= mdio_o_d;
      mdio_oe_q <= mdio_oe_d;
      wr_stb_q  <= wr_stb_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      rd_stb_q  <= rd_stb_d;
      rd_addr_q <= rd_addr_d;
      abort_q   <= abort_d;
    end
  end

  assign mdio_o      = mdio_o_q;
  assign mdio_oe     = mdio_oe_q;
  assign wr_strobe   = wr_stb_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign rd_strobe   = rd_stb_q;
  assign rd_addr     = rd_addr_q;
  assign frame_abort = abort_q;

endmodule
`default_nettype wire

// File: doc/mdio_slave.md
Name: mdio_slave

Overview:
- IEEE 802.3 Clause 22 MDIO responder (management slave).
- It is the far end of the eth_mdc/eth_mdio master interface. It decodes read and write frames addressed to its PHY address and exposes them as a simple register-access bus to local logic, such as PCS configuration/status registers or a loopback PHY model for the Ethernet path.
- MDC is treated as data and oversampled in the system clock domain.

Parameters:
- PHY_ADDR, 5'd1, PHY address this block responds to.
- PREAMBLE_LEN, 32, number of consecutive 1 bits required before ST (1..32).

Ports:
- clock  in  1  system clock; must be at least 8x the MDC frequency.
- reset  in  1  asynchronous, active-high reset.
- mdc  in  1  management clock from the master (asynchronous to clock).
- mdio_i  in  1  MDIO pad input.
- mdio_o  out  1  MDIO pad output value.
- mdio_oe  out  1  MDIO pad output enable (1 = drive).
- wr_strobe  out  1  one-cycle pulse on a completed write frame.
- wr_addr  out  5  register address of the write.
- wr_data  out  16  write data.
- rd_strobe  out  1  one-cycle pulse when a read frame's REGAD is known.
- rd_addr  out  5  register address of the read.
- rd_data  in  16  read data from local logic; must be valid 2 clocks after rd_strobe and held to the end of the frame.
- frame_abort  out  1  one-cycle pulse when a frame is dropped after ST was accepted.

Behaviour:
- Reset: async assert/deassert on reset=1. All outputs reset to 0, state is IDLE, preamble count is 0, shift registers are 0.
- Input capture: mdc and mdio_i each pass through a 2-FF synchronizer. Both use the same number of stages so they stay aligned.
- Edge detect: rise = synced mdc 0->1. All frame decoding happens only on clock cycles where rise=1; the bit value is the synced mdio at that cycle.
- IDLE:
  - On a 1 bit, pre_cnt increments, saturating at PREAMBLE_LEN.
  - On a 0 bit with pre_cnt==PREAMBLE_LEN, go to ST2 (this 0 is the first ST bit).
  - On a 0 bit otherwise, pre_cnt is cleared.
- ST2: bit must be 1 -> OP. Otherwise frame_abort, clear pre_cnt, go to IDLE.
- OP: collect 2 bits. 10 = read, 01 = write, then PHYAD. 00 or 11: abort -> IDLE.
- PHYAD: collect 5 bits, MSB first. On mismatch with PHY_ADDR, go to IDLE silently: no abort pulse and mdio_oe never asserts.
- REGAD: collect 5 bits, MSB first, then TA.
  - On a read, rd_strobe pulses for 1 clock on the cycle after the 5th REGAD bit, with rd_addr valid on that same cycle.
- TA, write: bits must be 1 then 0; otherwise abort -> IDLE.
- TA, read:
  - Capture rd_data into the tx shift register at the TA1 rise.
  - On the TA1 rise, drive mdio_oe=1 and mdio_o=0.
  - On the TA2 rise, mdio_o=rd_data[15].
  - On the rise of data bit k (k=15..1), mdio_o=bit k-1.
  - On the rise of data bit 0, mdio_oe=0 and mdio_o=0, go to IDLE.
  - Each output change is registered on the cycle after rise. The value is therefore stable for most of the MDC period before the master's next rising-edge sample.
- DATA, write: shift in 16 bits, MSB first. On the cycle after the 16th bit, wr_strobe=1 for 1 clock and wr_addr/wr_data are updated; they hold until the next write. Then go to IDLE.
- After any frame, pre_cnt restarts from 0. Back-to-back frames each need a full preamble.
- mdio_oe is only ever 1 between the read TA1 and data bit 0. It is forced to 0 in every other state and on abort.
- Reset mid-frame: mdio_oe drops asynchronously, no strobes are issued, and the frame is lost.
- Width rules: pre_cnt is 6 bits; bit counter is 4 bits; address shift registers are 5 bits; data shift registers are 16 bits.

Decomposition:
- Package mdio_pkg: state enum (IDLE, ST2, OP, PHYAD, REGAD, TA, DATA), opcode constants OP_READ=2'b10 and OP_WRITE=2'b01, ST=2'b01, field widths 5/5/16.
- Sub-module mdio_sync_edge: 2-FF synchronizer with rising-edge detect, instantiated for mdc. The same synchronizer is used without edge output for mdio_i.

Test Plan:
- Write: 32x1, 01, 01, PHYAD 00001, REGAD 00100, TA 10, data 0xBEEF -> one wr_strobe with wr_addr=4, wr_data=0xBEEF; mdio_oe stays 0 throughout.
- Read: preamble, 01, 10, PHYAD 00001, REGAD 00010 -> rd_strobe with rd_addr=2.
  - Bench returns rd_data=0xA5C3.
  - Master samples TA2=0, then bits 1010_0101_1100_0011; mdio_oe falls after the last bit.
- Wrong address: read frame to PHYAD 00011 -> no rd_strobe, mdio_oe never 1, no frame_abort. A following valid write is accepted.
- Short preamble: 31 ones then a write frame -> no wr_strobe. A repeat with 32 ones succeeds.
- Bad write TA: TA=11 -> frame_abort pulses once, no wr_strobe. Opcode 11 -> frame_abort.
- Reset mid-read: assert reset during data bit 7 -> mdio_oe=0 immediately. After release, a full read frame returns correct data.
